// File: rtl/ysyx_23060208_axi_arbiter.sv
// Two-master to one-slave AXI4-Lite arbiter: M0 (IFU, read only) and M1 (EXU, read/write).
// Optional feature: define ARB_RR_EN for round-robin between M0 and M1 (fixed M1 priority otherwise).
module ysyx_23060208_axi_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    // M0 (IFU) read channels
    input  logic [DATA_WIDTH-1:0]     m0_araddr_i,
    input  logic                      m0_arvalid_i,
    output logic                      m0_arready_o,
    output logic [DATA_WIDTH-1:0]     m0_rdata_o,
    output logic [1:0]                m0_rresp_o,
    output logic                      m0_rvalid_o,
    input  logic                      m0_rready_i,
    // M1 (EXU) write channels
    input  logic [DATA_WIDTH-1:0]     m1_awaddr_i,
    input  logic                      m1_awvalid_i,
    output logic                      m1_awready_o,
    input  logic [DATA_WIDTH-1:0]     m1_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]   m1_wstrb_i,
    input  logic                      m1_wvalid_i,
    output logic                      m1_wready_o,
    output logic [1:0]                m1_bresp_o,
    output logic                      m1_bvalid_o,
    input  logic                      m1_bready_i,
    // M1 (EXU) read channels
    input  logic [DATA_WIDTH-1:0]     m1_araddr_i,
    input  logic                      m1_arvalid_i,
    output logic                      m1_arready_o,
    output logic [DATA_WIDTH-1:0]     m1_rdata_o,
    output logic [1:0]                m1_rresp_o,
    output logic                      m1_rvalid_o,
    input  logic                      m1_rready_i,
    // Slave (memory) port
    output logic [DATA_WIDTH-1:0]     s_awaddr_o,
    output logic                      s_awvalid_o,
    input  logic                      s_awready_i,
    output logic [DATA_WIDTH-1:0]     s_wdata_o,
    output logic [DATA_WIDTH/8-1:0]   s_wstrb_o,
    output logic                      s_wvalid_o,
    input  logic                      s_wready_i,
    input  logic [1:0]                s_bresp_i,
    input  logic                      s_bvalid_i,
    output logic                      s_bready_o,
    output logic [DATA_WIDTH-1:0]     s_araddr_o,
    output logic                      s_arvalid_o,
    input  logic                      s_arready_i,
    input  logic [DATA_WIDTH-1:0]     s_rdata_i,
    input  logic [1:0]                s_rresp_i,
    input  logic                      s_rvalid_i,
    output logic                      s_rready_o
);

    // state | meaning
    // IDLE  | no owner; arbitrate among pending requests
    // M0_AR | M0 owns slave AR channel
    // M0_R  | waiting for / forwarding M0 read data
    // M1_AR | M1 owns slave AR channel
    // M1_R  | waiting for / forwarding M1 read data
    // M1_W  | forwarding M1 AW and W independently until both handshaken
    // M1_B  | forwarding M1 write response
    typedef enum logic [2:0] {
        IDLE,
        M0_AR,
        M0_R,
        M1_AR,
        M1_R,
        M1_W,
        M1_B
    } state_e;

    state_e state_q, state_d;
    logic   aw_done_q, aw_done_d;
    logic   w_done_q, w_done_d;

    logic   m1_wr_req;
    logic   m1_req;
    logic   grant_m1;
    logic   aw_hs;
    logic   w_hs;

    assign m1_wr_req = m1_awvalid_i | m1_wvalid_i;
    assign m1_req    = m1_wr_req | m1_arvalid_i;
    assign aw_hs     = m1_awvalid_i & ~aw_done_q & s_awready_i;
    assign w_hs      = m1_wvalid_i & ~w_done_q & s_wready_i;

`ifdef ARB_RR_EN
    // Pointer resets to "M1 granted last" so the first contested grant goes to M0.
    logic last_m1_q, last_m1_d;

    assign grant_m1 = m1_req & (~m0_arvalid_i | ~last_m1_q);

    always_comb begin
        last_m1_d = last_m1_q;
        if (state_q == IDLE) begin
            if (grant_m1) begin
                last_m1_d = 1'b1;
            end else if (m0_arvalid_i) begin
                last_m1_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_m1_q <= 1'b1;
        end else begin
            last_m1_q <= last_m1_d;
        end
    end
`else
    assign grant_m1 = m1_req;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;

        m0_arready_o = 1'b0;
        m0_rdata_o   = '0;
        m0_rresp_o   = 2'b00;
        m0_rvalid_o  = 1'b0;
        m1_awready_o = 1'b0;
        m1_wready_o  = 1'b0;
        m1_bresp_o   = 2'b00;
        m1_bvalid_o  = 1'b0;
        m1_arready_o = 1'b0;
        m1_rdata_o   = '0;
        m1_rresp_o   = 2'b00;
        m1_rvalid_o  = 1'b0;

        s_awaddr_o   = '0;
        s_awvalid_o  = 1'b0;
        s_wdata_o    = '0;
        s_wstrb_o    = '0;
        s_wvalid_o   = 1'b0;
        s_bready_o   = 1'b0;
        s_araddr_o   = '0;
        s_arvalid_o  = 1'b0;
        s_rready_o   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (grant_m1) begin
                    state_d = m1_wr_req ? M1_W : M1_AR;
                end else if (m0_arvalid_i) begin
                    state_d = M0_AR;
                end
            end
            M0_AR: begin
                s_araddr_o   = m0_araddr_i;
                s_arvalid_o  = m0_arvalid_i;
                m0_arready_o = s_arready_i;
                if (m0_arvalid_i && s_arready_i) begin
                    state_d = M0_R;
                end
            end
            M0_R: begin
                m0_rdata_o  = s_rdata_i;
                m0_rresp_o  = s_rresp_i;
                m0_rvalid_o = s_rvalid_i;
                s_rready_o  = m0_rready_i;
                if (s_rvalid_i && m0_rready_i) begin
                    state_d = IDLE;
                end
            end
            M1_AR: begin
                s_araddr_o   = m1_araddr_i;
                s_arvalid_o  = m1_arvalid_i;
                m1_arready_o = s_arready_i;
                if (m1_arvalid_i && s_arready_i) begin
                    state_d = M1_R;
                end
            end
            M1_R: begin
                m1_rdata_o  = s_rdata_i;
                m1_rresp_o  = s_rresp_i;
                m1_rvalid_o = s_rvalid_i;
                s_rready_o  = m1_rready_i;
                if (s_rvalid_i && m1_rready_i) begin
                    state_d = IDLE;
                end
            end
            M1_W: begin
                // A finished channel is masked so the slave never sees a second beat.
                s_awaddr_o   = m1_awaddr_i;
                s_awvalid_o  = m1_awvalid_i & ~aw_done_q;
                m1_awready_o = s_awready_i & ~aw_done_q;
                s_wdata_o    = m1_wdata_i;
                s_wstrb_o    = m1_wstrb_i;
                s_wvalid_o   = m1_wvalid_i & ~w_done_q;
                m1_wready_o  = s_wready_i & ~w_done_q;
                aw_done_d    = aw_done_q | aw_hs;
                w_done_d     = w_done_q | w_hs;
                if (aw_done_d && w_done_d) begin
                    state_d = M1_B;
                end
            end
            M1_B: begin
                m1_bresp_o  = s_bresp_i;
                m1_bvalid_o = s_bvalid_i;
                s_bready_o  = m1_bready_i;
                if (s_bvalid_i && m1_bready_i) begin
                    state_d   = IDLE;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_23060208_axi_arbiter.sv
// Bench for ysyx_23060208_axi_arbiter: behavioural slave memory, per-master expected-response
// queues filled at issue time and drained by a response monitor.
module tb_ysyx_23060208_axi_arbiter;

    localparam int DW     = 32;
    localparam int BUDGET = 60;

    logic            clk;
    logic            rst_ni;

    logic [DW-1:0]   m0_araddr;
    logic            m0_arvalid, m0_arready;
    logic [DW-1:0]   m0_rdata;
    logic [1:0]      m0_rresp;
    logic            m0_rvalid, m0_rready;

    logic [DW-1:0]   m1_awaddr;
    logic            m1_awvalid, m1_awready;
    logic [DW-1:0]   m1_wdata;
    logic [3:0]      m1_wstrb;
    logic            m1_wvalid, m1_wready;
    logic [1:0]      m1_bresp;
    logic            m1_bvalid, m1_bready;
    logic [DW-1:0]   m1_araddr;
    logic            m1_arvalid, m1_arready;
    logic [DW-1:0]   m1_rdata;
    logic [1:0]      m1_rresp;
    logic            m1_rvalid, m1_rready;

    logic [DW-1:0]   s_awaddr;
    logic            s_awvalid, s_awready;
    logic [DW-1:0]   s_wdata;
    logic [3:0]      s_wstrb;
    logic            s_wvalid, s_wready;
    logic [1:0]      s_bresp;
    logic            s_bvalid, s_bready;
    logic [DW-1:0]   s_araddr;
    logic            s_arvalid, s_arready;
    logic [DW-1:0]   s_rdata;
    logic [1:0]      s_rresp;
    logic            s_rvalid, s_rready;

    ysyx_23060208_axi_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .m0_araddr_i(m0_araddr), .m0_arvalid_i(m0_arvalid), .m0_arready_o(m0_arready),
        .m0_rdata_o(m0_rdata), .m0_rresp_o(m0_rresp), .m0_rvalid_o(m0_rvalid), .m0_rready_i(m0_rready),
        .m1_awaddr_i(m1_awaddr), .m1_awvalid_i(m1_awvalid), .m1_awready_o(m1_awready),
        .m1_wdata_i(m1_wdata), .m1_wstrb_i(m1_wstrb), .m1_wvalid_i(m1_wvalid), .m1_wready_o(m1_wready),
        .m1_bresp_o(m1_bresp), .m1_bvalid_o(m1_bvalid), .m1_bready_i(m1_bready),
        .m1_araddr_i(m1_araddr), .m1_arvalid_i(m1_arvalid), .m1_arready_o(m1_arready),
        .m1_rdata_o(m1_rdata), .m1_rresp_o(m1_rresp), .m1_rvalid_o(m1_rvalid), .m1_rready_i(m1_rready),
        .s_awaddr_o(s_awaddr), .s_awvalid_o(s_awvalid), .s_awready_i(s_awready),
        .s_wdata_o(s_wdata), .s_wstrb_o(s_wstrb), .s_wvalid_o(s_wvalid), .s_wready_i(s_wready),
        .s_bresp_i(s_bresp), .s_bvalid_i(s_bvalid), .s_bready_o(s_bready),
        .s_araddr_o(s_araddr), .s_arvalid_o(s_arvalid), .s_arready_i(s_arready),
        .s_rdata_i(s_rdata), .s_rresp_i(s_rresp), .s_rvalid_i(s_rvalid), .s_rready_o(s_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- slave memory model ----------------
    logic        slv_arready, slv_awready, slv_wready;
    logic [1:0]  slv_rresp, slv_bresp;
    int          slv_rdelay;

    bit   [31:0] mem [64];
    bit          written [64];

    logic        r_busy;
    int          r_wait;
    logic        aw_got, w_got;
    logic [31:0] aw_addr_q, w_data_q;
    logic [3:0]  w_strb_q;

    assign s_arready = slv_arready;
    assign s_awready = slv_awready;
    assign s_wready  = slv_wready;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        case (a)
            32'h8000_0000: return 32'h0000_0413;
            32'h8000_1000: return 32'h1122_3344;
            default:       return a ^ 32'hA5A5_0000;
        endcase
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return written[a[13:8]] ? mem[a[13:8]] : init_val(a);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_busy    <= 1'b0;
            r_wait    <= 0;
            s_rvalid  <= 1'b0;
            s_rdata   <= '0;
            s_rresp   <= 2'b00;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            s_bvalid  <= 1'b0;
            s_bresp   <= 2'b00;
        end else begin
            if (s_arvalid && s_arready) begin
                r_busy   <= 1'b1;
                r_wait   <= slv_rdelay;
                s_rvalid <= (slv_rdelay == 0);
                s_rdata  <= mem_rd(s_araddr);
                s_rresp  <= slv_rresp;
            end else if (r_busy && !s_rvalid) begin
                r_wait <= r_wait - 1;
                if (r_wait == 1) s_rvalid <= 1'b1;
            end
            if (s_rvalid && s_rready) begin
                s_rvalid <= 1'b0;
                r_busy   <= 1'b0;
            end
            if (s_awvalid && s_awready) begin
                aw_got    <= 1'b1;
                aw_addr_q <= s_awaddr;
            end
            if (s_wvalid && s_wready) begin
                w_got    <= 1'b1;
                w_data_q <= s_wdata;
                w_strb_q <= s_wstrb;
            end
            if (aw_got && w_got && !s_bvalid) begin
                s_bvalid                 <= 1'b1;
                s_bresp                  <= slv_bresp;
                mem[aw_addr_q[13:8]]     <= merge(mem_rd(aw_addr_q), w_data_q, w_strb_q);
                written[aw_addr_q[13:8]] <= 1'b1;
                aw_got                   <= 1'b0;
                w_got                    <= 1'b0;
            end
            if (s_bvalid && s_bready) s_bvalid <= 1'b0;
        end
    end

    // ---------------- scoreboard ----------------
    logic [33:0] m0_q[$];
    logic [33:0] m1r_q[$];
    logic [1:0]  m1b_q[$];
    logic [31:0] ar_order_q[$];
    int          m0_issue_cyc, m0_r_cyc;
    logic        m1_quiet;

    always begin
        logic [33:0] e;
        logic [1:0]  b;
        @(negedge clk);
        #1;
        if (m0_rvalid && m0_rready) begin
            if (m0_q.size() == 0) chk("m0_r_unexpected", m0_rvalid, 1'b0);
            else begin
                e = m0_q.pop_front();
                chk("m0_rdata", m0_rdata, e[31:0]);
                chk("m0_rresp", m0_rresp, e[33:32]);
                m0_r_cyc = cyc + 1;
            end
        end
        if (m1_rvalid && m1_rready) begin
            if (m1r_q.size() == 0) chk("m1_r_unexpected", m1_rvalid, 1'b0);
            else begin
                e = m1r_q.pop_front();
                chk("m1_rdata", m1_rdata, e[31:0]);
                chk("m1_rresp", m1_rresp, e[33:32]);
            end
        end
        if (m1_bvalid && m1_bready) begin
            if (m1b_q.size() == 0) chk("m1_b_unexpected", m1_bvalid, 1'b0);
            else begin
                b = m1b_q.pop_front();
                chk("m1_bresp", m1_bresp, b);
            end
        end
        if (r_busy) chk("s_ar_during_r", s_arvalid, 1'b0);
        if (s_arvalid && s_arready && ar_order_q.size() > 0)
            chk("ar_grant_order", s_araddr, ar_order_q.pop_front());
        if (m1_quiet)
            chk("m1_outputs_quiet", {m1_arready, m1_awready, m1_wready, m1_rvalid, m1_bvalid}, 5'd0);
    end

    // ---------------- master drivers ----------------
    task automatic m0_read(input logic [31:0] addr, input logic [31:0] d, input logic [1:0] r);
        int n;
        @(negedge clk);
        m0_araddr  = addr;
        m0_arvalid = 1'b1;
        m0_q.push_back({r, d});
        m0_issue_cyc = cyc;
        n = 0;
        #1;
        while (!m0_arready && n < BUDGET) begin @(negedge clk); #1; n++; end
        if (n >= BUDGET) chk("m0_ar_timeout", m0_arready, 1'b1);
        @(posedge clk);
        #1;
        m0_arvalid = 1'b0;
        m0_araddr  = '0;
    endtask

    task automatic m1_read(input logic [31:0] addr, input logic [31:0] d, input logic [1:0] r);
        int n;
        @(negedge clk);
        m1_araddr  = addr;
        m1_arvalid = 1'b1;
        m1r_q.push_back({r, d});
        n = 0;
        #1;
        while (!m1_arready && n < BUDGET) begin @(negedge clk); #1; n++; end
        if (n >= BUDGET) chk("m1_ar_timeout", m1_arready, 1'b1);
        @(posedge clk);
        #1;
        m1_arvalid = 1'b0;
        m1_araddr  = '0;
    endtask

    task automatic m1_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input logic [1:0] exp_b);
        m1b_q.push_back(exp_b);
        fork
            begin
                int n;
                repeat (aw_dly + 1) @(negedge clk);
                m1_awaddr  = addr;
                m1_awvalid = 1'b1;
                n = 0;
                #1;
                while (!m1_awready && n < BUDGET) begin @(negedge clk); #1; n++; end
                if (n >= BUDGET) chk("m1_aw_timeout", m1_awready, 1'b1);
                @(posedge clk);
                #1;
                m1_awvalid = 1'b0;
            end
            begin
                int n;
                repeat (w_dly + 1) @(negedge clk);
                m1_wdata  = d;
                m1_wstrb  = strb;
                m1_wvalid = 1'b1;
                n = 0;
                #1;
                while (!m1_wready && n < BUDGET) begin @(negedge clk); #1; n++; end
                if (n >= BUDGET) chk("m1_w_timeout", m1_wready, 1'b1);
                @(posedge clk);
                #1;
                m1_wvalid = 1'b0;
            end
        join
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((m0_q.size() + m1r_q.size() + m1b_q.size()) != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (n >= 200) chk("drain_timeout", m0_q.size() + m1r_q.size() + m1b_q.size(), 0);
        repeat (2) @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ni = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    function automatic logic [11:0] ctrl_vec();
        return {m0_arready, m0_rvalid, m1_awready, m1_wready, m1_bvalid, m1_arready,
                m1_rvalid, s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_ni     = 1'b0;
        m0_araddr  = '0; m0_arvalid = 1'b0; m0_rready = 1'b1;
        m1_awaddr  = '0; m1_awvalid = 1'b0; m1_wdata  = '0; m1_wstrb = '0; m1_wvalid = 1'b0;
        m1_bready  = 1'b1; m1_araddr = '0; m1_arvalid = 1'b0; m1_rready = 1'b1;
        slv_arready = 1'b1; slv_awready = 1'b1; slv_wready = 1'b1;
        slv_rresp  = 2'b00; slv_bresp = 2'b00; slv_rdelay = 0;
        m1_quiet   = 1'b0;
        m0_issue_cyc = 0; m0_r_cyc = 0;

        #1;
        chk("rst_ctrl", ctrl_vec(), 12'd0);
        chk("rst_rdata", {m0_rdata, m1_rdata}, 64'd0);
        chk("rst_resp", {m0_rresp, m1_rresp, m1_bresp}, 6'd0);
        chk("rst_s_addr", {s_awaddr, s_araddr}, 64'd0);
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;

        // M0 read alone: data 0x413, R handshake on the third edge, M1 side silent
        m1_quiet = 1'b1;
        m0_read(32'h8000_0000, 32'h0000_0413, 2'b00);
        wait_drain();
        m1_quiet = 1'b0;
        chk("m0_read_latency", m0_r_cyc - m0_issue_cyc, 3);

        // M1 write with W leading AW by 2 cycles, then read-back through M0
        m1_write(32'h8000_1000, 32'hDEAD_BEEF, 4'b0011, 2, 0, 2'b00);
        wait_drain();
        chk("idle_after_b", {s_awvalid, s_wvalid, s_bready, m1_bvalid}, 4'd0);
        m0_read(32'h8000_1000, 32'h1122_BEEF, 2'b00);
        wait_drain();
        chk("m0_latency_after_write", m0_r_cyc - m0_issue_cyc, 3);

        // Simultaneous reads right after reset
        do_reset();
`ifdef ARB_RR_EN
        ar_order_q.push_back(32'h8000_0100);
        ar_order_q.push_back(32'h8000_0200);
`else
        ar_order_q.push_back(32'h8000_0200);
        ar_order_q.push_back(32'h8000_0100);
`endif
        fork
            m0_read(32'h8000_0100, 32'h25A5_0100, 2'b00);
            m1_read(32'h8000_0200, 32'h25A5_0200, 2'b00);
        join
        wait_drain();
        chk("ar_order_consumed", ar_order_q.size(), 0);

        // Slave stalls R for 5 cycles while M0 immediately re-requests
        slv_rdelay = 5;
        m0_read(32'h8000_0000, 32'h0000_0413, 2'b00);
        m0_read(32'h8000_0100, 32'h25A5_0100, 2'b00);
        wait_drain();
        slv_rdelay = 0;

        // SLVERR on an M1 read is passed through, M0 must stay silent
        slv_rresp = 2'b10;
        m1_read(32'h8000_0200, 32'h25A5_0200, 2'b10);
        wait_drain();
        slv_rresp = 2'b00;

        // M1 write and read issued together: write goes first, read sees new data
        slv_bresp = 2'b10;
        fork
            m1_write(32'h8000_3000, 32'h0BAD_F00D, 4'hF, 0, 0, 2'b10);
            m1_read(32'h8000_3000, 32'h0BAD_F00D, 2'b00);
        join
        wait_drain();
        slv_bresp = 2'b00;

        // Reset in M1_W after AW has completed but before W
        @(negedge clk);
        m1_awaddr  = 32'h8000_2000;
        m1_awvalid = 1'b1;
        begin
            int n;
            n = 0;
            #1;
            while (!m1_awready && n < BUDGET) begin @(negedge clk); #1; n++; end
            if (n >= BUDGET) chk("rst_test_aw_timeout", m1_awready, 1'b1);
        end
        @(posedge clk);
        #1;
        m1_awvalid = 1'b0;
        @(negedge clk);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("rst_mid_ctrl", ctrl_vec(), 12'd0);
        chk("rst_mid_data", {s_awaddr, s_wdata}, 64'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        m1_write(32'h8000_2000, 32'hCAFE_F00D, 4'hF, 0, 0, 2'b00);
        wait_drain();
        m1_read(32'h8000_2000, 32'hCAFE_F00D, 2'b00);
        wait_drain();

        chk("queues_empty", m0_q.size() + m1r_q.size() + m1b_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
